// File: rtl/sig_gen_pkg.sv
// Shared types and constants for the phase-accumulator signal generator.
// The LFSR constants are sized for the default 8-bit fractional phase.
package sig_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Galois taps for x^8 + x^6 + x^5 + x^4 + 1 (maximal length); the seed must be nonzero.
    localparam logic [31:0] LFSR_SEED = 32'h0000_00A5;
    localparam logic [31:0] LFSR_TAPS = 32'h0000_00B8;

endpackage

// File: rtl/sig_lfsr.sv
// Galois LFSR used as sub-LSB dither for the phase addresses.
// Only instantiated when SIG_PHASE_DITHER_EN is defined.
module sig_lfsr #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 'hB8,
    parameter logic [WIDTH-1:0]  SEED  = 'h01
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sig_phase_acc.sv
// Phase-accumulator address generator for a dual-port sine ROM (addr1 = phase, addr2 = phase +
// offset). Continuous or counted-burst operation. Optional dither: define SIG_PHASE_DITHER_EN.
module sig_phase_acc
    import sig_gen_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned FRAC_WIDTH    = 8,
    parameter int unsigned CYCLE_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              en,
    input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr,
    input  logic [ADDRESS_WIDTH-1:0]          offset,
    input  logic [CYCLE_WIDTH-1:0]            burst_cycles,
    output logic [ADDRESS_WIDTH-1:0]          addr1,
    output logic [ADDRESS_WIDTH-1:0]          addr2,
    output logic                              valid,
    output logic                              wrap,
    output logic                              done,
    output logic                              busy
);

    localparam int unsigned PW = ADDRESS_WIDTH + FRAC_WIDTH;

    state_t                   state_q, state_d;
    logic [PW-1:0]            acc_q, acc_d;
    logic [PW-1:0]            incr_q, incr_d;
    logic [CYCLE_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CYCLE_WIDTH-1:0]   burst_q, burst_d;
    logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
    logic                     valid_q, valid_d;
    logic                     wrap_q, wrap_d;
    logic                     done_q, done_d;
    logic                     wrap_pend_q, wrap_pend_d;

    logic [PW:0]              sum;
    logic                     carry;
    logic [CYCLE_WIDTH-1:0]   cnt_inc;
    logic [ADDRESS_WIDTH-1:0] phase_hi;
    logic                     advance;

    assign sum     = {1'b0, acc_q} + {1'b0, incr_q};
    assign carry   = sum[PW];
    assign cnt_inc = cnt_q + CYCLE_WIDTH'(1);
    assign advance = (state_q == RUN) && !stop && en;

`ifdef SIG_PHASE_DITHER_EN
    logic [FRAC_WIDTH-1:0] lfsr;
    logic [PW-1:0]         dithered;

    sig_lfsr #(
        .WIDTH (FRAC_WIDTH),
        .TAPS  (LFSR_TAPS[FRAC_WIDTH-1:0]),
        .SEED  (LFSR_SEED[FRAC_WIDTH-1:0])
    ) u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .step_i  (advance),
        .state_o (lfsr)
    );

    // Dither only perturbs the presented address; the accumulator stays exact.
    assign dithered = acc_q + PW'(lfsr);
    assign phase_hi = dithered[PW-1 -: ADDRESS_WIDTH];
`else
    assign phase_hi = acc_q[PW-1 -: ADDRESS_WIDTH];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        incr_d      = incr_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        wrap_pend_d = wrap_pend_q;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // valid is only high in IDLE right after the final burst sample.
                done_d = valid_q;
                if (start && !stop) begin
                    state_d     = RUN;
                    acc_d       = '0;
                    cnt_d       = '0;
                    incr_d      = incr;
                    burst_d     = burst_cycles;
                    wrap_pend_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end else if (en) begin
                    addr1_d     = phase_hi;
                    addr2_d     = phase_hi + offset;
                    valid_d     = 1'b1;
                    wrap_d      = wrap_pend_q;
                    wrap_pend_d = 1'b0;
                    acc_d       = sum[PW-1:0];
                    if (carry) begin
                        // Retune only at a period boundary so the waveform never glitches.
                        incr_d      = incr;
                        wrap_pend_d = 1'b1;
                        if (burst_q != '0) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == burst_q) begin
                                state_d = IDLE;
                                acc_d   = '0;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            incr_q      <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            incr_q      <= incr_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign addr1 = addr1_q;
    assign addr2 = addr2_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_sig_phase_acc.sv
// Self-checking bench for sig_phase_acc (dither off, 8.8 phase, 8-bit burst counter).
module tb_sig_phase_acc;

    localparam int AW = 8;
    localparam int FW = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst, start, stop, en;
    logic [AW+FW-1:0] incr;
    logic [AW-1:0]   offset;
    logic [CW-1:0]   burst_cycles;
    logic [AW-1:0]   addr1, addr2;
    logic            valid, wrap, done, busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sig_phase_acc #(
        .ADDRESS_WIDTH (AW),
        .FRAC_WIDTH    (FW),
        .CYCLE_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .en           (en),
        .incr         (incr),
        .offset       (offset),
        .burst_cycles (burst_cycles),
        .addr1        (addr1),
        .addr2        (addr2),
        .valid        (valid),
        .wrap         (wrap),
        .done         (done),
        .busy         (busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sample k of a run with constant step sits at phase k*inc (mod 2^16).
    function automatic int ref_addr(input longint inc, input longint k);
        return int'(((k * inc) >> FW) & 255);
    endfunction

    function automatic bit ref_wrap(input longint inc, input longint k);
        return (k > 0) && (((k * inc) >> (AW + FW)) != (((k - 1) * inc) >> (AW + FW)));
    endfunction

    // Samples emitted in an N-period burst: all k with floor(k*inc/2^16) < N.
    function automatic int ref_burst_len(input longint inc, input longint n);
        return int'((n * 65536 + inc - 1) / inc);
    endfunction

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_valid", valid, 0);
        tick();
        chk("stop_done", done, 0);
    endtask

    // One run with constant incr/offset; en is high en_pct percent of the cycles.
    task automatic run_seq(input int inc, input int off, input int n, input int en_pct,
                           input int nsamp, output int nvalid, output int nwrap);
        int k, total, cyc, last;
        bit e;
        k = 0; cyc = 0; last = 0; nvalid = 0; nwrap = 0;
        total = (n != 0) ? ref_burst_len(inc, n) : nsamp;
        incr = 16'(inc); offset = 8'(off); burst_cycles = 8'(n); en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", valid, 0);
        while (k < total && cyc < 20000) begin
            e = ($urandom_range(99) < en_pct);
            en = e;
            tick();
            cyc++;
            chk("run_done", done, 0);
            if (e) begin
                last = ref_addr(inc, k);
                chk("run_valid", valid, 1);
                chk("run_addr1", addr1, last);
                chk("run_addr2", addr2, (last + off) & 255);
                chk("run_wrap", wrap, ref_wrap(inc, k));
                nvalid += int'(valid);
                nwrap  += int'(wrap);
                k++;
                chk("run_busy", busy, (n != 0 && k == total) ? 0 : 1);
            end else begin
                chk("pause_valid", valid, 0);
                chk("pause_wrap", wrap, 0);
                if (k > 0) chk("pause_addr1", addr1, last);
            end
        end
        chk("run_sample_count", k, total);
        en = 1'b0;
        if (n != 0) begin
            tick();
            chk("burst_end_valid", valid, 0);
            chk("burst_done", done, 1);
            tick();
            chk("burst_done_clear", done, 0);
        end else begin
            pulse_stop();
        end
    endtask

    typedef struct {
        int inc;
        int off;
        int idx;
        int a1;
        int a2;
        int wr;
    } vec_t;

    initial begin
        vec_t vecs[11];
        int nv, nw, s, e_a;

        initial_wd_guard();
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
        incr = '0; offset = '0; burst_cycles = '0;
        tick();
        tick();
        chk("rst_addr1", addr1, 0);
        chk("rst_addr2", addr2, 0);
        chk("rst_valid", valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        vecs[0]  = '{16'h0100, 8'h40, 0,   8'h00, 8'h40, 0};
        vecs[1]  = '{16'h0100, 8'h40, 192, 8'hC0, 8'h00, 0};
        vecs[2]  = '{16'h0100, 8'h40, 255, 8'hFF, 8'h3F, 0};
        vecs[3]  = '{16'h0100, 8'h40, 256, 8'h00, 8'h40, 1};
        vecs[4]  = '{16'h0080, 8'h00, 1,   8'h00, 8'h00, 0};
        vecs[5]  = '{16'h0080, 8'h00, 2,   8'h01, 8'h01, 0};
        vecs[6]  = '{16'h0080, 8'h00, 5,   8'h02, 8'h02, 0};
        vecs[7]  = '{16'h0300, 8'h10, 86,  8'h02, 8'h12, 1};
        vecs[8]  = '{16'h0300, 8'h10, 100, 8'h2C, 8'h3C, 0};
        vecs[9]  = '{16'hFFFF, 8'h01, 1,   8'hFF, 8'h00, 0};
        vecs[10] = '{16'hFFFF, 8'h01, 2,   8'hFF, 8'h00, 1};

        foreach (vecs[i]) begin
            incr = 16'(vecs[i].inc); offset = 8'(vecs[i].off); burst_cycles = '0;
            start = 1'b1;
            tick();
            start = 1'b0;
            en = 1'b1;
            for (int j = 0; j <= vecs[i].idx; j++) tick();
            en = 1'b0;
            chk($sformatf("vec%0d_valid", i), valid, 1);
            chk($sformatf("vec%0d_addr1", i), addr1, vecs[i].a1);
            chk($sformatf("vec%0d_addr2", i), addr2, vecs[i].a2);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].wr);
            pulse_stop();
        end

        // Basic two-period burst.
        run_seq(16'h0100, 0, 2, 100, 0, nv, nw);
        chk("basic_valid_count", nv, 512);
        chk("basic_wrap_count", nw, 1);

        // Retune mid-period takes effect only after the wrap; start while running is ignored.
        incr = 16'h0100; offset = '0; burst_cycles = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        for (s = 0; s <= 258; s++) begin
            if (s == 100) incr = 16'h0200;
            start = (s == 120);
            tick();
            e_a = (s < 256) ? s : 2 * (s - 256);
            chk("retune_addr1", addr1, e_a);
            if (s == 256) chk("retune_wrap", wrap, 1);
        end
        start = 1'b0;
        en = 1'b0;
        pulse_stop();

        // Pause for 3 cycles, then stop and start in the same cycle.
        incr = 16'h0100; offset = 8'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("hold_valid", valid, 0);
            chk("hold_addr1", addr1, 4);
            chk("hold_addr2", addr2, 8'h44);
        end
        en = 1'b1;
        tick();
        chk("resume_valid", valid, 1);
        chk("resume_addr1", addr1, 5);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stopstart_busy", busy, 0);
        chk("stopstart_valid", valid, 0);
        tick();
        chk("stopstart_done", done, 0);
        chk("stopstart_idle", busy, 0);
        en = 1'b0;

        // Reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        for (int j = 0; j < 10; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        chk("midrst_addr1", addr1, 0);
        chk("midrst_addr2", addr2, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_wrap", wrap, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        tick();

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            run_seq(int'($urandom_range(16'hFFFF, 16'h0800)), int'($urandom_range(255)),
                    int'($urandom_range(3)), int'($urandom_range(100, 60)), 150, nv, nw);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic initial_wd_guard();
        fork
            begin
                #500000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "simulation timeout");
            end
        join_none
    endtask

endmodule
